cpu_ctrl_unit: RTL and testbench

Control unit for the week-1 microprocessor top. It fetches 8-bit instructions over a valid/ready handshake, decodes them, and issues one-cycle control strobes to the accumulator/ALU datapath, including the `write` (store) strobe. It maintains the program counter and halts on HLT or an illegal opcode. It sits between instruction memory and the datapath inside `top`.

---
 rtl/cpu_ctrl_pkg.sv | 50 +++++
 rtl/cpu_ctrl_if.sv | 24 ++
 rtl/cpu_pc_reg.sv | 28 ++
 rtl/cpu_ctrl_unit.sv | 99 +++++++++
 tb/tb_cpu_ctrl_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, state encoding and ALU op codes
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_ST  = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

  function automatic logic is_acc_op(input logic [3:0] op);
    return (op >= OP_LDI) && (op <= OP_XOR);
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// rtl/cpu_ctrl_if.sv - instruction fetch handshake and datapath control bus
interface cpu_ctrl_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
);
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_rdy;
  logic [2:0]         alu_op;
  logic               acc_we;
  logic               write;
  logic [ADDR_W-1:0]  wr_addr;
  logic               zero;

  modport master (
    input  instr, instr_valid, zero,
    output instr_rdy, alu_op, acc_we, write, wr_addr
  );

  modport slave (
    output instr, instr_valid, zero,
    input  instr_rdy, alu_op, acc_we, write, wr_addr
  );
endinterface

// File: rtl/cpu_pc_reg.sv
// rtl/cpu_pc_reg.sv - program counter with clear, load and increment
module cpu_pc_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] pc_o
);
  logic [W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (clr_i)       pc_d = '0;
    else if (load_i) pc_d = load_val_i;
    else if (inc_i)  pc_d = pc_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;
endmodule

// File: rtl/cpu_ctrl_unit.sv
// rtl/cpu_ctrl_unit.sv - fetch/decode/execute controller for the accumulator CPU
module cpu_ctrl_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  cpu_ctrl_if.master        bus,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);
  state_t             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               illegal_q, illegal_d;
  logic               pc_clr, pc_inc, pc_load;
  logic [3:0]         opcode;
  logic [ADDR_W-1:0]  operand;
  logic               exec_live;

  assign opcode  = ir_q[INSTR_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    pc_clr    = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_clr  = 1'b1;
        end
      end
      ST_FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (opcode == OP_HLT) begin
          state_d = ST_HALT;
        end else if (is_illegal(opcode)) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else if (opcode == OP_JMP || (opcode == OP_JZ && bus.zero)) begin
          pc_load = 1'b1;
        end else begin
          pc_inc = 1'b1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  cpu_pc_reg #(.W(ADDR_W)) u_pc (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (pc_clr),
    .inc_i      (pc_inc),
    .load_i     (pc_load),
    .load_val_i (operand),
    .pc_o       (pc)
  );

  // Strobes are masked by rst so a reset landing on EXEC aborts the store/load.
  assign exec_live     = (state_q == ST_EXEC) && !rst;
  assign bus.acc_we    = exec_live && is_acc_op(opcode);
  assign bus.write     = exec_live && (opcode == OP_ST);
  assign bus.alu_op    = alu_op_of(opcode);
  assign bus.wr_addr   = operand;
  assign bus.instr_rdy = (state_q == ST_FETCH);
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted        = (state_q == ST_HALT);
  assign illegal       = illegal_q;
endmodule

// File: tb/tb_cpu_ctrl_unit.sv
// tb/tb_cpu_ctrl_unit.sv - directed self-checking bench for cpu_ctrl_unit
module tb_cpu_ctrl_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] pc;
  logic       busy, halted, illegal;
  logic [7:0] mem [16];
  int         tests = 0;
  int         failed = 0;

  cpu_ctrl_if #(.ADDR_W(4), .INSTR_W(8)) bus ();

  cpu_ctrl_unit #(.ADDR_W(4), .INSTR_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus.master),
    .pc      (pc),
    .busy    (busy),
    .halted  (halted),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  assign bus.instr = mem[pc];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_strobes(input string tag, input logic aw, input logic wr);
    chk({tag, "_acc_we"}, {7'd0, bus.acc_we}, {7'd0, aw});
    chk({tag, "_write"}, {7'd0, bus.write}, {7'd0, wr});
  endtask

  task automatic run_instr(input string tag, input logic [3:0] exp_pc);
    repeat (3) tick();
    chk(tag, {4'd0, pc}, {4'd0, exp_pc});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    bus.instr_valid = 1'b1;
    bus.zero = 1'b0;
    do_reset();

    chk("rst_pc", {4'd0, pc}, 8'd0);
    chk("rst_rdy", {7'd0, bus.instr_rdy}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_halted", {7'd0, halted}, 8'd0);
    chk("rst_illegal", {7'd0, illegal}, 8'd0);
    chk("rst_alu_op", {5'd0, bus.alu_op}, 8'd0);
    chk("rst_wr_addr", {4'd0, bus.wr_addr}, 8'd0);
    chk_strobes("rst", 1'b0, 1'b0);

    // LDI 5; ST 3; HLT
    mem[0] = 8'h15; mem[1] = 8'h73; mem[2] = 8'hF0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("c1_rdy", {7'd0, bus.instr_rdy}, 8'd1);
    chk("c1_busy", {7'd0, busy}, 8'd1);
    chk_strobes("c1", 1'b0, 1'b0);
    tick();
    chk("c2_rdy", {7'd0, bus.instr_rdy}, 8'd0);
    chk_strobes("c2", 1'b0, 1'b0);
    tick();
    chk_strobes("c3_ldi", 1'b1, 1'b0);
    chk("c3_alu_op", {5'd0, bus.alu_op}, 8'd0);
    tick();
    chk("c4_pc", {4'd0, pc}, 8'd1);
    chk_strobes("c4", 1'b0, 1'b0);
    tick();
    tick();
    chk_strobes("c6_st", 1'b0, 1'b1);
    chk("c6_wr_addr", {4'd0, bus.wr_addr}, 8'd3);
    tick();
    chk_strobes("c7", 1'b0, 1'b0);
    tick();
    tick();
    chk_strobes("c9_hlt", 1'b0, 1'b0);
    tick();
    chk("halt_halted", {7'd0, halted}, 8'd1);
    chk("halt_busy", {7'd0, busy}, 8'd0);
    chk("halt_pc", {4'd0, pc}, 8'd2);
    chk("halt_illegal", {7'd0, illegal}, 8'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("halt_start_ign", {7'd0, halted}, 8'd1);

    // Fetch stall, then branches
    do_reset();
    mem[0] = 8'h21; mem[1] = 8'h99; mem[9] = 8'h84; mem[4] = 8'h99;
    mem[5] = 8'h8F; mem[15] = 8'h80;
    bus.instr_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_rdy", {7'd0, bus.instr_rdy}, 8'd1);
      chk("stall_pc", {4'd0, pc}, 8'd0);
      chk_strobes("stall", 1'b0, 1'b0);
    end
    bus.instr_valid = 1'b1;
    tick();
    tick();
    chk_strobes("add_exec", 1'b1, 1'b0);
    chk("add_alu_op", {5'd0, bus.alu_op}, 8'd1);
    tick();
    chk("add_pc", {4'd0, pc}, 8'd1);
    bus.zero = 1'b1;
    run_instr("jz_taken_pc", 4'd9);
    bus.zero = 1'b0;
    run_instr("jmp4_pc", 4'd4);
    run_instr("jz_not_taken_pc", 4'd5);
    run_instr("jmp15_pc", 4'd15);
    run_instr("jmp0_at15_pc", 4'd0);
    mem[0] = 8'h8F; mem[15] = 8'h00;
    run_instr("jmp15b_pc", 4'd15);
    run_instr("nop_wrap_pc", 4'd0);

    // Illegal opcode 0xB
    do_reset();
    mem[0] = 8'hB7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk_strobes("ill_exec", 1'b0, 1'b0);
    tick();
    chk("ill_halted", {7'd0, halted}, 8'd1);
    chk("ill_flag", {7'd0, illegal}, 8'd1);
    chk("ill_pc", {4'd0, pc}, 8'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ill_start_ign", {7'd0, halted}, 8'd1);
    chk("ill_busy", {7'd0, busy}, 8'd0);
    do_reset();
    chk("ill_cleared", {7'd0, illegal}, 8'd0);

    // Reset during EXEC of ST 5
    mem[0] = 8'h75;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk_strobes("st_exec", 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk_strobes("st_abort", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_rdy", {7'd0, bus.instr_rdy}, 8'd0);
    chk("abort_wr_addr", {4'd0, bus.wr_addr}, 8'd0);
    chk("abort_pc", {4'd0, pc}, 8'd0);
    tick();
    chk("abort_idle", {7'd0, busy}, 8'd0);

    // rst and start together in IDLE
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", {7'd0, busy}, 8'd0);
    chk("rst_start_rdy", {7'd0, bus.instr_rdy}, 8'd0);
    tick();
    chk("rst_start_idle", {7'd0, busy}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
